apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master.sv | 237 +++++++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: queues register read/write commands in a small FIFO and
// issues each one as an APB transfer (IDLE -> SETUP -> ACCESS), reporting a
// one-cycle completion pulse per command.
//
// Optional build macro: APB_TIMEOUT_EN
//   Bounds the ACCESS-phase wait to TIMEOUT_CYC cycles of PREADY=0. The
//   abandoned transfer completes with rsp_err=1 and rsp_rdata=0.
//   Without it, ACCESS waits for PREADY indefinitely and rsp_err stays 0.
//
// Handshake: a command is taken on a PCLK edge where cmd_valid && cmd_ready.
// cmd_ready depends only on FIFO occupancy (never on cmd_valid) and is low
// while the FIFO is full, even in a cycle where the head is being popped.
// rsp_valid is a single-cycle pulse with no back-pressure. dbg_state mirrors
// the FSM state register for observation.
module apb_cmd_master #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA,
   output logic [1:0]        dbg_state
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W = 1 + ADDR_W + DATA_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   // Command FIFO: entry = {write, addr, wdata}
   logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_last_q, push_last_d;
   logic             full, push, pop, avail;
   logic [ENT_W-1:0] head;

   // FSM state and registered APB / response outputs
   state_t            state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              done, launch;

`ifdef APB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
   logic [7:0] to_cnt_q, to_cnt_d;
`else
   // The wait limit only has meaning when the timeout is built in.
   if (TIMEOUT_CYC < 1) begin : g_timeout_param_unused
   end
`endif

   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   // The entry written on the previous edge is not visible to the FSM yet,
   // which gives the one-cycle no-bypass latency from push to pop.
   assign avail     = (count_q > CNT_W'(push_last_q));
   assign head      = fifo_mem_q[rd_ptr_q];
   assign pop       = launch;

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      push_last_d = push;
   end

   // FIFO storage write
   always_ff @(posedge PCLK) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
      end
   end

   // FIFO pointer/occupancy registers; reset discards all queued commands
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         push_last_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         push_last_q <= push_last_d;
      end
   end

   // APB transfer sequencing and completion reporting
   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      done        = 1'b0;
      launch      = 1'b0;
`ifdef APB_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            launch    = avail;
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
            to_cnt_d  = 8'd0;
`endif
         end
         ST_ACCESS: begin
            if (PREADY) begin
               done        = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
            end
`ifdef APB_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               done        = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
`endif
            if (done) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = ST_IDLE;
               launch    = avail;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
      // Popping the head starts a SETUP phase, from IDLE or straight out of ACCESS
      if (launch) begin
         state_d                      = ST_SETUP;
         psel_d                       = 1'b1;
         penable_d                    = 1'b0;
         {pwrite_d, paddr_d, pwdata_d} = head;
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= ST_IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         to_cnt_q    <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   assign PSELx     = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (count_q != '0) || (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master: table-driven single transfers, directed
// multi-cycle sequences, and randomized traffic against a transaction-level
// model (in-order command list plus a register-file image).
`timescale 1ns/1ps
module tb_apb_cmd_master;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int CW     = 1 + ADDR_W + DATA_W;

   // ---------------- clock / reset / DUT ----------------
   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid, rsp_err, busy;
   logic [DATA_W-1:0] rsp_rdata;
   logic              PSELx, PENABLE, PWRITE, PREADY;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA, PRDATA;
   logic [1:0]        dbg_state;

   always #5 PCLK = ~PCLK;

   apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PRDATA(PRDATA), .dbg_state(dbg_state)
   );

   // ---------------- slave model and scoreboard ----------------
   int          checks   = 0;
   int          failures = 0;
   logic        mon_en       = 1'b0;
   logic        drv_override = 1'b1;
   logic [7:0]  prdata_drv   = 8'h00;
   logic [7:0]  slv_mem   [256];
   logic [7:0]  model_mem [256];
   logic [CW-1:0]     exp_cmd_q[$];
   logic [DATA_W-1:0] exp_q[$];

   assign PRDATA = drv_override ? prdata_drv : slv_mem[PADDR];

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] prdata;
      int         delay;
      logic [7:0] exp_rdata;
   } vec_t;
   vec_t vecs[6];

   int n, acc, seen, lowrun;

   function automatic logic [7:0] init_val(input logic [7:0] a);
      logic [7:0] r;
      r = a * 8'd7 + 8'd3;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic do_reset();
      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      PREADY    = 1'b0;
      tick();
      tick();
      PRESET    = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_psel"},      PSELx,     0);
      chk({tag, "_penable"},   PENABLE,   0);
      chk({tag, "_pwrite"},    PWRITE,    0);
      chk({tag, "_paddr"},     PADDR,     0);
      chk({tag, "_pwdata"},    PWDATA,    0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
      chk({tag, "_rsp_err"},   rsp_err,   0);
      chk({tag, "_busy"},      busy,      0);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
   endtask

   task automatic model_accept(input logic w, input logic [7:0] a, input logic [7:0] d);
      exp_cmd_q.push_back({w, a, d});
      if (w) begin
         model_mem[a] = d;
         exp_q.push_back(8'h00);
      end else begin
         exp_q.push_back(model_mem[a]);
      end
   endtask

   // One command from idle: push timing, SETUP/ACCESS contents, wait states, completion
   task automatic run_vec(input vec_t v, input int idx);
      cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
      prdata_drv = v.prdata; PREADY = 1'b0;
      chk($sformatf("v%0d_ready", idx), cmd_ready, 1);
      tick();
      cmd_valid = 1'b0; cmd_write = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
      chk($sformatf("v%0d_busy", idx), busy, 1);
      chk($sformatf("v%0d_psel_n0", idx), PSELx, 0);
      tick();
      chk($sformatf("v%0d_psel_n1", idx), PSELx, 0);
      tick();
      chk($sformatf("v%0d_setup_psel", idx), PSELx, 1);
      chk($sformatf("v%0d_setup_pen", idx), PENABLE, 0);
      chk($sformatf("v%0d_setup_pwrite", idx), PWRITE, v.wr);
      chk($sformatf("v%0d_setup_paddr", idx), PADDR, v.addr);
      chk($sformatf("v%0d_setup_pwdata", idx), PWDATA, v.wdata);
      tick();
      chk($sformatf("v%0d_access_psel", idx), PSELx, 1);
      chk($sformatf("v%0d_access_pen", idx), PENABLE, 1);
      chk($sformatf("v%0d_access_paddr", idx), PADDR, v.addr);
      chk($sformatf("v%0d_access_pwdata", idx), PWDATA, v.wdata);
      for (int k = 0; k <= v.delay; k++) begin
         PREADY = (k == v.delay);
         tick();
         if (k < v.delay) begin
            chk($sformatf("v%0d_wait%0d_pen", idx, k), PENABLE, 1);
            chk($sformatf("v%0d_wait%0d_rsp", idx, k), rsp_valid, 0);
         end
      end
      PREADY = 1'b0;
      chk($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1);
      chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d_rsp_err", idx), rsp_err, 0);
      chk($sformatf("v%0d_idle_psel", idx), PSELx, 0);
      tick();
      chk($sformatf("v%0d_rsp_pulse", idx), rsp_valid, 0);
      chk($sformatf("v%0d_rdata_hold", idx), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d_paddr_hold", idx), PADDR, v.addr);
      chk($sformatf("v%0d_idle_busy", idx), busy, 0);
   endtask

   // Transaction monitor for the randomized phase
   always @(negedge PCLK) begin
      if (mon_en && !PRESET) begin
         if (PSELx && !PENABLE) begin
            if (exp_cmd_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rand_setup_extra: got addr %0h expected no transfer", PADDR);
            end else begin
               logic [CW-1:0] e;
               e = exp_cmd_q.pop_front();
               chk("rand_setup_cmd", {PWRITE, PADDR, PWDATA}, e);
            end
         end
         if (PSELx && PENABLE && PREADY && PWRITE) slv_mem[PADDR] = PWDATA;
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rand_rsp_extra: got rdata %0h expected no response", rsp_rdata);
            end else begin
               logic [DATA_W-1:0] e;
               e = exp_q.pop_front();
               chk("rand_rsp_rdata", rsp_rdata, e);
               chk("rand_rsp_err", rsp_err, 0);
            end
         end
      end
   end

   // Run-time bound
   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: got timeout expected test end");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 8'h02, 8'hA5, 8'h77, 0, 8'h00};
      vecs[1] = '{1'b0, 8'h04, 8'h00, 8'h3C, 3, 8'h3C};
      vecs[2] = '{1'b0, 8'hFF, 8'h12, 8'hC3, 0, 8'hC3};
      vecs[3] = '{1'b1, 8'h80, 8'h5A, 8'hFF, 2, 8'h00};
      vecs[4] = '{1'b0, 8'h00, 8'hFF, 8'h81, 1, 8'h81};
      vecs[5] = '{1'b1, 8'h7E, 8'hFF, 8'h00, 5, 8'h00};
      for (int i = 0; i < 256; i++) begin
         slv_mem[i]   = init_val(8'(i));
         model_mem[i] = init_val(8'(i));
      end

      // Reset state
      do_reset();
      chk_reset_vals("por");

      // Table-driven single transfers
      drv_override = 1'b1;
      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Fill while stalled; a push offered at the popping edge of a full FIFO is refused
      do_reset();
      drv_override = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'(10 + i); cmd_wdata = 8'h00;
         chk($sformatf("fill_ready%0d", i), cmd_ready, 1);
         tick();
      end
      cmd_valid = 1'b0;
      chk("full_ready", cmd_ready, 0);
      chk("full_busy", busy, 1);
      tick();
      tick();
      chk("full_ready_hold", cmd_ready, 0);
      cmd_valid = 1'b1; cmd_addr = 8'd20; PREADY = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("after_pop_ready", cmd_ready, 1);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (rsp_valid) begin
            if (n < 5) chk($sformatf("fill_rsp%0d", n), rsp_rdata, init_val(8'(10 + n)));
            n++;
         end
         tick();
      end
      chk("fill_rsp_count", n, 5);

      // Three queued writes run back-to-back
      do_reset();
      PREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'(8'h30 + i); cmd_wdata = 8'(i);
         tick();
      end
      cmd_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("b2b_psel%0d", c), PSELx, 1);
         chk($sformatf("b2b_pen%0d", c), PENABLE, c % 2);
         chk($sformatf("b2b_paddr%0d", c), PADDR, 8'h30 + c / 2);
         tick();
      end
      chk("b2b_psel_end", PSELx, 0);

      // ACCESS with PREADY held low
      do_reset();
      PREADY = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44;
      tick();
      cmd_valid = 1'b0;
      tick(); tick(); tick();
`ifdef APB_TIMEOUT_EN
      acc = 0; seen = 0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
         if (rsp_valid) seen = 1;
         else begin
            if (PENABLE) acc++;
            tick();
         end
      end
      chk("to_seen", seen, 1);
      chk("to_access_cycles", acc, 16);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_rdata", rsp_rdata, 0);
      chk("to_psel", PSELx, 0);
`else
      seen = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (rsp_valid) seen++;
      end
      chk("wait_no_rsp", seen, 0);
      chk("wait_psel", PSELx, 1);
      chk("wait_pen", PENABLE, 1);
      PREADY = 1'b1;
      tick();
      PREADY = 1'b0;
      chk("wait_rsp_valid", rsp_valid, 1);
      chk("wait_rsp_err", rsp_err, 0);
      tick();
`endif

      // Reset during ACCESS with two commands queued
      do_reset();
      PREADY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'(8'h50 + i);
         tick();
      end
      cmd_valid = 1'b0;
      for (int c = 0; c < 20 && !(PSELx && PENABLE); c++) tick();
      chk("mrst_reach_access", PSELx && PENABLE, 1);
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      chk_reset_vals("mrst");
      PREADY = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (rsp_valid || PSELx) seen++;
      end
      chk("mrst_no_activity", seen, 0);

      // Randomized traffic against the transaction-level model
      do_reset();
      drv_override = 1'b0;
      for (int i = 0; i < 256; i++) begin
         slv_mem[i]   = init_val(8'(i));
         model_mem[i] = init_val(8'(i));
      end
      exp_cmd_q.delete();
      exp_q.delete();
      mon_en = 1'b1;
      lowrun = 0;
      for (int c = 0; c < 400; c++) begin
         PREADY = (lowrun >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
         lowrun = PREADY ? 0 : lowrun + 1;
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_write = 1'($urandom_range(0, 1));
         cmd_addr  = 8'($urandom_range(0, 15));
         cmd_wdata = 8'($urandom_range(0, 255));
         if (cmd_valid && cmd_ready) model_accept(cmd_write, cmd_addr, cmd_wdata);
         tick();
      end
      cmd_valid = 1'b0;
      for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
         PREADY = (lowrun >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
         lowrun = PREADY ? 0 : lowrun + 1;
         tick();
      end
      tick();
      chk("rand_rsp_drain", exp_q.size(), 0);
      chk("rand_cmd_drain", exp_cmd_q.size(), 0);
      chk("rand_idle_busy", busy, 0);
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
